// File: rtl/noc_endpoint.sv
// rtl/noc_endpoint.sv - NoC endpoint with credit-based flit transmit and a circular receive FIFO
module noc_endpoint #(
  parameter int XCOORD   = 0,
  parameter int YCOORD   = 0,
  parameter int CREDITS  = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_dest_i,
  input  logic [7:0]  tx_payload_i,
  output logic        tx_ready_o,
  output logic [15:0] net_data_o,
  output logic        net_enable_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_enable_i,
  output logic        net_credit_o,
  output logic [15:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [2:0]  err_o
);

  localparam int              AW         = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int              CW         = $clog2(RX_DEPTH + 1);
  localparam logic [3:0]      CRED_MAX   = 4'(CREDITS);
  localparam logic [7:0]      HERE       = {4'(XCOORD), 4'(YCOORD)};
  localparam logic [CW-1:0]   FULL_COUNT = CW'(RX_DEPTH);
  localparam logic [AW-1:0]   LAST_PTR   = AW'(RX_DEPTH - 1);

  logic [3:0]    credit_cnt;
  logic [15:0]   fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    err_q;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          wr_en;
  logic          credit_excess;

  // tx_ready depends only on the registered credit count, never on inputs
  assign tx_ready_o    = (credit_cnt != 4'd0);
  assign accept        = tx_valid_i & tx_ready_o;
  assign credit_excess = net_credit_i & ~accept & (credit_cnt == CRED_MAX);

  assign rx_valid_o = (count != '0);
  assign rx_data_o  = fifo_mem[rd_ptr];
  assign pop        = rx_valid_o & rx_ready_i;
  assign fifo_full  = (count == FULL_COUNT);
  // A same-cycle pop frees the slot, so a full FIFO still takes the write
  assign wr_en      = net_enable_i & (~fifo_full | pop);
  assign err_o      = err_q;

  // Register the accepted flit toward the router; data holds between sends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_enable_o <= 1'b0;
      net_data_o   <= 16'h0000;
    end else begin
      net_enable_o <= accept;
      if (accept) net_data_o <= {tx_payload_i, tx_dest_i};
    end
  end

  // Credit counter: send consumes, router credit restores, both cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CRED_MAX;
    end else if (accept && !net_credit_i) begin
      credit_cnt <= credit_cnt - 4'd1;
    end else if (net_credit_i && !accept && credit_cnt != CRED_MAX) begin
      credit_cnt <= credit_cnt + 4'd1;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)   rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // RX storage; contents are invalidated by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= net_data_i;
  end

  // Credit return pulse one cycle after each pop, plus sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_credit_o <= 1'b0;
      err_q        <= 3'b000;
    end else begin
      net_credit_o <= pop;
      if (net_enable_i && fifo_full && !pop)  err_q[0] <= 1'b1;
      if (net_enable_i && net_data_i[7:0] != HERE) err_q[1] <= 1'b1;
      if (credit_excess)                      err_q[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_endpoint.sv
// tb/tb_noc_endpoint.sv - self-checking bench for noc_endpoint
module tb_noc_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid_i;
  logic [7:0]  tx_dest_i;
  logic [7:0]  tx_payload_i;
  logic        tx_ready_o;
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i;
  logic [15:0] net_data_i;
  logic        net_enable_i;
  logic        net_credit_o;
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [2:0]  err_o;

  always #5 clk = ~clk;

  noc_endpoint #(.XCOORD(2), .YCOORD(3), .CREDITS(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_dest_i(tx_dest_i), .tx_payload_i(tx_payload_i),
    .tx_ready_o(tx_ready_o), .net_data_o(net_data_o), .net_enable_o(net_enable_o),
    .net_credit_i(net_credit_i), .net_data_i(net_data_i), .net_enable_i(net_enable_i),
    .net_credit_o(net_credit_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .err_o(err_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credits as an integer, RX FIFO as a queue
  int          m_cred;
  logic [15:0] m_q[$];
  logic        m_net_en;
  logic [15:0] m_net_data;
  logic        m_credit_o;
  logic [2:0]  m_err;

  function automatic void model_reset();
    m_cred = 4; m_q.delete(); m_net_en = 0; m_net_data = 0; m_credit_o = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    bit acc;
    bit pop;
    int sz;
    acc = tx_valid_i && (m_cred > 0);
    pop = rx_ready_i && (m_q.size() > 0);
    sz  = m_q.size();
    m_net_en = acc;
    if (acc) m_net_data = {tx_payload_i, tx_dest_i};
    if (acc && !net_credit_i) m_cred--;
    else if (net_credit_i && !acc) begin
      if (m_cred == 4) m_err[2] = 1'b1;
      else m_cred++;
    end
    if (pop) void'(m_q.pop_front());
    if (net_enable_i) begin
      if (sz < 4 || pop) m_q.push_back(net_data_i);
      else m_err[0] = 1'b1;
      if (net_data_i[7:0] != 8'h23) m_err[1] = 1'b1;
    end
    m_credit_o = pop;
  endfunction

  task automatic check_model();
    check("rnd tx_ready", 16'(tx_ready_o), 16'(m_cred != 0));
    check("rnd net_enable", 16'(net_enable_o), 16'(m_net_en));
    check("rnd net_data", net_data_o, m_net_data);
    check("rnd net_credit", 16'(net_credit_o), 16'(m_credit_o));
    check("rnd rx_valid", 16'(rx_valid_o), 16'(m_q.size() != 0));
    if (m_q.size() != 0) check("rnd rx_data", rx_data_o, m_q[0]);
    check("rnd err", 16'(err_o), 16'(m_err));
  endtask

  task automatic idle_inputs();
    tx_valid_i = 0; tx_dest_i = 0; tx_payload_i = 0; net_credit_i = 0;
    net_data_i = 0; net_enable_i = 0; rx_ready_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic txv; logic [7:0] dest; logic [7:0] pay; logic cr; logic nen; logic [15:0] nd; logic rdy;
    logic e_rdy; logic e_nen; logic [15:0] e_nd; logic e_cro; logic e_rxv; logic [15:0] e_rxd; logic [2:0] e_err;
  } vec_t;

  vec_t vecs[9];
  int   pulses;
  logic [5:0] mask;

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    // Reset values while rst is high, before any clock edge
    check("reset tx_ready", 16'(tx_ready_o), 16'd1);
    check("reset rx_valid", 16'(rx_valid_o), 16'd0);
    check("reset net_enable", 16'(net_enable_o), 16'd0);
    check("reset net_data", net_data_o, 16'h0000);
    check("reset net_credit", 16'(net_credit_o), 16'd0);
    check("reset err", 16'(err_o), 16'd0);
    do_reset();

    // Directed table: send, hold, receive/route check, pops, credit corner cases
    vecs[0] = '{1, 8'h23, 8'h5A, 0, 0, 16'h0000, 0,  1, 1, 16'h5A23, 0, 0, 16'h0000, 3'b000};
    vecs[1] = '{0, 8'h00, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 16'h5A23, 0, 0, 16'h0000, 3'b000};
    vecs[2] = '{0, 8'h00, 8'h00, 0, 1, 16'h1123, 0,  1, 0, 16'h5A23, 0, 1, 16'h1123, 3'b000};
    vecs[3] = '{0, 8'h00, 8'h00, 0, 1, 16'h0045, 1,  1, 0, 16'h5A23, 1, 1, 16'h0045, 3'b010};
    vecs[4] = '{0, 8'h00, 8'h00, 0, 0, 16'h0000, 1,  1, 0, 16'h5A23, 1, 0, 16'h0000, 3'b010};
    vecs[5] = '{0, 8'h00, 8'h00, 0, 0, 16'h0000, 0,  1, 0, 16'h5A23, 0, 0, 16'h0000, 3'b010};
    vecs[6] = '{0, 8'h00, 8'h00, 1, 0, 16'h0000, 0,  1, 0, 16'h5A23, 0, 0, 16'h0000, 3'b010};
    vecs[7] = '{1, 8'h71, 8'hC3, 1, 0, 16'h0000, 0,  1, 1, 16'hC371, 0, 0, 16'h0000, 3'b010};
    vecs[8] = '{0, 8'h00, 8'h00, 1, 0, 16'h0000, 0,  1, 0, 16'hC371, 0, 0, 16'h0000, 3'b110};
    for (int i = 0; i < 9; i++) begin
      tx_valid_i = vecs[i].txv; tx_dest_i = vecs[i].dest; tx_payload_i = vecs[i].pay;
      net_credit_i = vecs[i].cr; net_enable_i = vecs[i].nen; net_data_i = vecs[i].nd;
      rx_ready_i = vecs[i].rdy;
      step();
      check($sformatf("vec%0d tx_ready", i), 16'(tx_ready_o), 16'(vecs[i].e_rdy));
      check($sformatf("vec%0d net_enable", i), 16'(net_enable_o), 16'(vecs[i].e_nen));
      check($sformatf("vec%0d net_data", i), net_data_o, vecs[i].e_nd);
      check($sformatf("vec%0d net_credit", i), 16'(net_credit_o), 16'(vecs[i].e_cro));
      check($sformatf("vec%0d rx_valid", i), 16'(rx_valid_o), 16'(vecs[i].e_rxv));
      if (vecs[i].e_rxv) check($sformatf("vec%0d rx_data", i), rx_data_o, vecs[i].e_rxd);
      check($sformatf("vec%0d err", i), 16'(err_o), 16'(vecs[i].e_err));
    end

    // Credit exhaustion, then a single returned credit allows one more send
    do_reset();
    tx_valid_i = 1; tx_dest_i = 8'h23;
    pulses = 0; mask = '0;
    for (int k = 0; k < 6; k++) begin
      tx_payload_i = 8'(k);
      step();
      if (net_enable_o) begin pulses++; mask[k] = 1'b1; end
    end
    check("exhaust pulses", 16'(pulses), 16'd4);
    check("exhaust mask", 16'(mask), 16'h000F);
    check("exhaust ready", 16'(tx_ready_o), 16'd0);
    net_credit_i = 1;
    step();
    net_credit_i = 0;
    check("zero-credit no send", 16'(net_enable_o), 16'd0);
    check("credit restores ready", 16'(tx_ready_o), 16'd1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (net_enable_o) pulses++;
    end
    check("one more send", 16'(pulses), 16'd1);
    check("ready after resend", 16'(tx_ready_o), 16'd0);

    // Full FIFO with simultaneous write and pop
    do_reset();
    net_enable_i = 1;
    for (int k = 0; k < 4; k++) begin
      net_data_i = {8'(k), 8'h23};
      step();
    end
    net_data_i = 16'h0523; rx_ready_i = 1;
    step();
    net_enable_i = 0; rx_ready_i = 0;
    check("full wr+pop head", rx_data_o, 16'h0123);
    check("full wr+pop credit", 16'(net_credit_o), 16'd1);
    check("full wr+pop err", 16'(err_o), 16'd0);
    check("full wr+pop valid", 16'(rx_valid_o), 16'd1);

    // Overflow: fifth write dropped, then four pops in order
    do_reset();
    net_enable_i = 1;
    for (int k = 0; k < 5; k++) begin
      net_data_i = {8'(k), 8'h23};
      step();
    end
    net_enable_i = 0;
    check("overflow err", 16'(err_o), 16'd1);
    rx_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pop%0d data", k), rx_data_o, {8'(k), 8'h23});
      step();
      check($sformatf("pop%0d credit", k), 16'(net_credit_o), 16'd1);
    end
    check("drained valid", 16'(rx_valid_o), 16'd0);
    step();
    check("empty pop no credit", 16'(net_credit_o), 16'd0);
    rx_ready_i = 0;

    // Reset mid-stream with three entries queued and one credit left
    do_reset();
    tx_valid_i = 1; tx_dest_i = 8'h44; net_enable_i = 1;
    for (int k = 0; k < 3; k++) begin
      tx_payload_i = 8'(k + 1);
      net_data_i = {8'(k), 8'h23};
      step();
    end
    check("pre-reset net_enable", 16'(net_enable_o), 16'd1);
    rx_ready_i = 1;
    #2;
    rst = 1'b1;
    #1;
    check("async rst tx_ready", 16'(tx_ready_o), 16'd1);
    check("async rst rx_valid", 16'(rx_valid_o), 16'd0);
    check("async rst net_enable", 16'(net_enable_o), 16'd0);
    check("async rst net_data", net_data_o, 16'h0000);
    check("async rst net_credit", 16'(net_credit_o), 16'd0);
    check("async rst err", 16'(err_o), 16'd0);
    step();
    check("in rst net_enable", 16'(net_enable_o), 16'd0);
    check("in rst net_credit", 16'(net_credit_o), 16'd0);
    idle_inputs();
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (net_enable_o || net_credit_o) pulses++;
    end
    check("post-rst strobes", 16'(pulses), 16'd0);
    check("post-rst rx_valid", 16'(rx_valid_o), 16'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tx_valid_i   = 1'($urandom_range(0, 1));
      tx_dest_i    = 8'($urandom);
      tx_payload_i = 8'($urandom);
      net_credit_i = ($urandom_range(0, 3) == 0);
      net_enable_i = ($urandom_range(0, 2) == 0);
      net_data_i   = {8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h23};
      rx_ready_i   = 1'($urandom_range(0, 1));
      model_step();
      step();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_endpoint.md
NOC_ENDPOINT -- requirements
Module: noc_endpoint

Interface
REQ-001 Parameter XCOORD, default 0: this node's 4-bit X coordinate.
REQ-002 Parameter YCOORD, default 0: this node's 4-bit Y coordinate.
REQ-003 Parameter CREDITS, default 4: initial TX credit count, equal to the router local input-buffer depth; valid range 1..15.
REQ-004 Parameter RX_DEPTH, default 4: receive FIFO depth; power of two, 2..16.
REQ-005 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_valid_i  input  1  core offers one flit.
REQ-008 tx_dest_i  input  8  destination header: [7:4] X, [3:0] Y.
REQ-009 tx_payload_i  input  8  flit payload.
REQ-010 tx_ready_o  output  1  endpoint can accept a flit this cycle.
REQ-011 net_data_o  output  16  flit to router local input port.
REQ-012 net_enable_o  output  1  net_data_o valid; one-cycle write strobe.
REQ-013 net_credit_i  input  1  router freed one local input-buffer slot.
REQ-014 net_data_i  input  16  flit from router local output port.
REQ-015 net_enable_i  input  1  net_data_i valid.
REQ-016 net_credit_o  output  1  one-cycle credit pulse back to router.
REQ-017 rx_data_o  output  16  head of receive FIFO.
REQ-018 rx_valid_o  output  1  receive FIFO not empty.
REQ-019 rx_ready_i  input  1  core consumes head flit.
REQ-020 err_o  output  3  sticky errors: [0] RX overflow, [1] misrouted flit, [2] credit overflow.

Function
REQ-021 Flit format SHALL be {payload[15:8], dest X[7:4], dest Y[3:0]}.
REQ-022 A 4-bit credit counter SHALL hold the number of sends still allowed and SHALL reset to CREDITS.
REQ-023 tx_ready_o SHALL be 1 exactly when the credit counter is nonzero, decoded from registered state only.
REQ-024 A TX accept occurs in the cycle in which tx_valid_i and tx_ready_o are both 1.
REQ-025 On an accept in cycle N, net_enable_o SHALL be 1 in cycle N+1, and net_data_o SHALL carry {tx_payload_i, tx_dest_i} as sampled in cycle N.
REQ-026 In cycles with no accept, net_enable_o SHALL be 0 and net_data_o SHALL hold its last value.
REQ-027 Credit counter update: accept only -> decrement by 1; net_credit_i only -> increment by 1; both in the same cycle -> unchanged.
REQ-028 If net_credit_i arrives with the counter at CREDITS and no accept in that cycle, the counter SHALL saturate at CREDITS and err_o[2] SHALL be set.
REQ-029 With the counter at 0, tx_valid_i SHALL be ignored (no accept); a net_credit_i in that cycle makes tx_ready_o 1 in the next cycle.
REQ-030 The RX FIFO SHALL be circular with RX_DEPTH entries, a write pointer, a read pointer and an occupancy count; pointers SHALL wrap from RX_DEPTH-1 to 0.
REQ-031 net_enable_i=1 SHALL write net_data_i into the FIFO in the same cycle.
REQ-032 rx_valid_o SHALL equal (count != 0); rx_data_o SHALL present the entry at the read pointer.
REQ-033 A pop occurs when rx_valid_o and rx_ready_i are both 1; rx_ready_i with the FIFO empty SHALL have no effect.
REQ-034 A pop in cycle N SHALL produce net_credit_o=1 in cycle N+1 only; otherwise net_credit_o SHALL be 0.
REQ-035 Write and pop in the same cycle SHALL both take effect with count unchanged, including when the FIFO is full.
REQ-036 A write to a full FIFO without a same-cycle pop SHALL drop the flit, leave FIFO state unchanged, and set err_o[0].
REQ-037 A received flit whose data[7:0] differs from {XCOORD[3:0], YCOORD[3:0]} SHALL still be stored and SHALL set err_o[1].
REQ-038 err_o bits SHALL be cleared only by rst.

Reset
REQ-039 While rst=1, regardless of clk: credit counter = CREDITS, FIFO pointers and count = 0, net_enable_o = 0, net_data_o = 0, net_credit_o = 0, err_o = 0; consequently tx_ready_o = 1, rx_valid_o = 0.
REQ-040 Reset asserted mid-transfer SHALL discard in-flight TX strobes and all FIFO contents; no net_enable_o or net_credit_o pulse SHALL appear during or due to reset.

Verification
REQ-041 Credit exhaustion (CREDITS=4): tx_valid_i held high with no net_credit_i -> exactly 4 net_enable_o pulses in cycles 1-4, then tx_ready_o=0; one net_credit_i -> exactly one more send.
REQ-042 Send 0x5A with dest 0x23 -> net_data_o = 0x5A23 with net_enable_o=1 in the cycle after the accept, counter decremented by 1.
REQ-043 XCOORD=2, YCOORD=3: receive 0x1123 then 0x0045 -> both delivered in order; err_o[1]=1 after the second flit only.
REQ-044 RX_DEPTH=4: five writes with rx_ready_i=0 -> fifth flit dropped, err_o[0]=1; then four pops -> four net_credit_o pulses, each one cycle after its pop, rx_valid_o=0 afterwards.
REQ-045 Simultaneous accept plus net_credit_i, and simultaneous write plus pop with the FIFO full -> counter and count unchanged, no error bits set.
REQ-046 rst pulsed mid-stream with the FIFO at 3 entries and the counter at 1 -> all REQ-039 values hold immediately and no strobes occur after release.
